// File: rtl/pipe_latch_elastic.sv
// Generic elastic pipeline latch between two CPU stages.
// Valid/ready handshake, flush, hold, optional skid entry and stall/flush stats.
module pipe_latch_elastic #(
    parameter int                DATA_W   = 64,
    parameter int                CTRL_W   = 16,
    parameter logic [CTRL_W-1:0] CTRL_RST = '0,
    parameter int                SKID     = 1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    input  logic              hold,
    input  logic              clr_stats,
    output logic [1:0]        occupancy,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
);

    localparam bit HAS_SKID = (SKID != 0);

    logic              m_valid, m_valid_n;
    logic [DATA_W-1:0] m_data, m_data_n;
    logic [CTRL_W-1:0] m_ctrl, m_ctrl_n;
    logic              s_valid, s_valid_n;
    logic [DATA_W-1:0] s_data, s_data_n;
    logic [CTRL_W-1:0] s_ctrl, s_ctrl_n;
    logic              rdy_q;
    logic              consume, accept, stall;
    logic [1:0]        occ_n;

    assign consume = m_valid & out_ready & ~hold & ~flush;
    assign accept  = in_valid & in_ready;
    assign stall   = m_valid & ~flush & ~(out_ready & ~hold);

    generate
        if (HAS_SKID) begin : g_skid
            assign in_ready = rdy_q & ~flush;
        end else begin : g_noskid
            assign in_ready = ~flush & (~m_valid | (out_ready & ~hold));
        end
    endgenerate

    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign out_ctrl  = m_ctrl;

    always_comb begin
        m_valid_n = m_valid;
        m_data_n  = m_data;
        m_ctrl_n  = m_ctrl;
        s_valid_n = s_valid;
        s_data_n  = s_data;
        s_ctrl_n  = s_ctrl;
        if (flush) begin
            m_valid_n = 1'b0;
            m_data_n  = '0;
            m_ctrl_n  = CTRL_RST;
            s_valid_n = 1'b0;
            s_data_n  = '0;
            s_ctrl_n  = CTRL_RST;
        end else if (m_valid & ~consume) begin
            // main is stuck, so a new entry can only land in the skid slot
            if (accept & HAS_SKID) begin
                s_valid_n = 1'b1;
                s_data_n  = in_data;
                s_ctrl_n  = in_ctrl;
            end
        end else if (s_valid) begin
            m_valid_n = 1'b1;
            m_data_n  = s_data;
            m_ctrl_n  = s_ctrl;
            s_valid_n = 1'b0;
            s_data_n  = '0;
            s_ctrl_n  = CTRL_RST;
        end else if (accept) begin
            m_valid_n = 1'b1;
            m_data_n  = in_data;
            m_ctrl_n  = in_ctrl;
        end else begin
            m_valid_n = 1'b0;
            m_data_n  = '0;
            m_ctrl_n  = CTRL_RST;
        end
    end

    assign occ_n = {1'b0, m_valid_n} + {1'b0, s_valid_n};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_ctrl    <= CTRL_RST;
            s_valid   <= 1'b0;
            s_data    <= '0;
            s_ctrl    <= CTRL_RST;
            rdy_q     <= 1'b1;
            occupancy <= 2'd0;
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            m_valid   <= m_valid_n;
            m_data    <= m_data_n;
            m_ctrl    <= m_ctrl_n;
            s_valid   <= s_valid_n;
            s_data    <= s_data_n;
            s_ctrl    <= s_ctrl_n;
            rdy_q     <= ~s_valid_n;
            occupancy <= occ_n;
            if (clr_stats) begin
                stall_cnt <= 16'd0;
                flush_cnt <= 16'd0;
            end else begin
                if (stall && stall_cnt != 16'hFFFF)
                    stall_cnt <= stall_cnt + 16'd1;
                if (flush && occupancy != 2'd0 && flush_cnt != 16'hFFFF)
                    flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/pipe_latch_elastic.md
Name: pipe_latch_elastic

Overview:
- Parametrised elastic pipeline latch that replaces fixed stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block.
- Carries an opaque data bundle and a control bundle with a valid/ready handshake, synchronous flush, external hold, and an optional 2-entry skid buffer.
- Provides saturating stall and flush statistics counters for pipeline performance debug.
- Sits between any two adjacent CPU pipeline stages.

Parameters:
- DATA_W, 64, width of the datapath bundle (operands, immediates, PC+4, ...).
- CTRL_W, 16, width of the control bundle (RegWr, dREN, dWEN, ALUOp, halt, ...).
- CTRL_RST, 0, value forced onto control bits of an empty or flushed entry (must encode a harmless NOP).
- SKID, 1, 0 = single entry; 1 = two entries (main + skid) with registered in_ready.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream presents an entry.
- in_ready  out  1  latch can accept; transfer occurs when in_valid & in_ready.
- in_data  in  DATA_W  upstream data bundle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- out_valid  out  1  main entry holds a valid instruction.
- out_ready  in  1  downstream consumes.
- out_data  out  DATA_W  main entry data.
- out_ctrl  out  CTRL_W  main entry control.
- flush  in  1  synchronous kill of all entries (branch mispredict, jump).
- hold  in  1  external stall; blocks output consumption.
- clr_stats  in  1  synchronous clear of the statistics counters.
- occupancy  out  2  number of valid entries, 0..SKID+1.
- stall_cnt  out  16  saturating count of stalled cycles.
- flush_cnt  out  16  saturating count of effective flushes.

Behaviour:
- Reset (nRST=0, async): all entries invalid; out_data=0; out_ctrl=CTRL_RST; occupancy=0; counters=0. With SKID=0, in_ready=1 after reset; with SKID=1, in_ready=1 after reset.
- Definitions:
  - consume = out_valid & out_ready & !hold & !flush.
  - accept = in_valid & in_ready.
- Latency: one cycle. An entry accepted at edge N appears on out_* after edge N with out_valid=1. FIFO order is always preserved.
- Outputs are driven from registers only; no combinational path from in_* to out_*.
- SKID=0:
  - in_ready = !flush & (!out_valid | (out_ready & !hold)). This is a combinational path from out_ready/hold.
  - Simultaneous consume and accept: main reloads with the new entry; out_valid stays 1.
- SKID=1:
  - in_ready is a register equal to "skid entry empty" after the edge. It is forced to 0 combinationally while flush=1.
  - Transitions (main M, skid S):
    - EMPTY + accept -> M.
    - M, no consume, accept -> M+S.
    - M+S, consume -> S moves to M; skid empty.
    - M+S, consume + accept is impossible, since in_ready=0.
    - M, consume + accept -> M (new).
    - M, consume only -> EMPTY.
- Vacated entry: when an entry becomes invalid without replacement, its ctrl is set to CTRL_RST and its data to 0 in the same edge. out_ctrl therefore never shows stale control while out_valid=0.
- hold=1: main and skid contents frozen except for acceptance into a free slot. out_* stable; no consume.
- flush=1 (priority over hold, accept, consume):
  - At the edge, all entries are invalidated and zeroed (ctrl=CTRL_RST).
  - Input presented in the flush cycle is discarded.
  - occupancy=0 next cycle.
- stall_cnt: +1 each cycle with out_valid & !flush & !(out_ready & !hold). Saturates at 0xFFFF.
- flush_cnt: +1 on each flush edge where occupancy>0. Flush on an empty latch does not count. Saturates at 0xFFFF.
- clr_stats: zeroes both counters at the edge. It has priority over increment in the same cycle and does not affect entries.
- occupancy: registered; equals the number of valid entries after each edge.

Test Plan:
- Reset mid-stream: SKID=1, two entries loaded, drop nRST asynchronously -> out_valid=0, out_ctrl=CTRL_RST, occupancy=0, in_ready=1 immediately, counters 0.
- Streaming: out_ready=1, in_valid=1 with in_data=1,2,3,4 on consecutive cycles -> out_data=1,2,3,4 one cycle later each; stall_cnt stays 0.
- Backpressure: SKID=1, out_ready=0, push A,B,C -> A in main, B in skid, in_ready=0 so C is held upstream. out_ready=1 then yields A,B,C in order; stall_cnt increments each blocked cycle.
- Hold: out_valid=1 with data 0x55, hold=1 and out_ready=1 for 3 cycles -> out_data stays 0x55, stall_cnt=3, no consume.
- Flush with data: occupancy=2, flush=1 with in_valid=1 carrying D -> next cycle occupancy=0, out_ctrl=CTRL_RST, D dropped, flush_cnt=1. A second flush while empty leaves flush_cnt=1.
- Saturation/clear: force 70000 stall cycles -> stall_cnt=0xFFFF. clr_stats together with a stall cycle -> stall_cnt=0.
